// File: rtl/ct_demux.sv
// ct_demux
//   Registered streaming demultiplexer. One valid/ready input stream that
//   carries a select field is steered to exactly one of lpm_size output
//   streams. An output register plus a one-entry skid register give full
//   throughput, a flop-driven i_ready and one cycle of latency. Beats leave
//   in acceptance order whatever their destination, so a stalled
//   destination blocks every destination behind it.
//
// Ports
//   clk      in   1            rising-edge clock
//   reset    in   1            asynchronous active-high reset
//   i_valid  in   1            input beat valid
//   i_ready  out  1            input ready, straight from a flop
//   i_data   in   lpm_width    input payload
//   i_sel    in   lpm_widths   destination index of the input beat
//   o_valid  out  lpm_size     per-destination valid, one-hot or zero
//   o_ready  in   lpm_size     per-destination ready
//   o_data   out  lpm_width    payload shared by all destinations
//   o_drop   out  1            pulse: an out-of-range beat was discarded
module ct_demux #(
    parameter int lpm_width  = 8,
    parameter int lpm_size   = 4,
    parameter int lpm_widths = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [lpm_width-1:0]  i_data,
    input  logic [lpm_widths-1:0] i_sel,
    output logic [lpm_size-1:0]   o_valid,
    input  logic [lpm_size-1:0]   o_ready,
    output logic [lpm_width-1:0]  o_data,
    output logic                  o_drop
);

    localparam int          SEL_SPAN = 2 ** lpm_widths;
    localparam int unsigned SIZE_U   = lpm_size;

    logic                  out_full;
    logic [lpm_width-1:0]  out_data;
    logic [lpm_widths-1:0] out_sel;
    logic                  skid_full;
    logic [lpm_width-1:0]  skid_data;
    logic [lpm_widths-1:0] skid_sel;

    logic                  accept;
    logic                  in_range;
    logic                  load;
    logic                  out_fire;
    logic                  out_free;
    logic                  skid_full_next;
    logic [SEL_SPAN-1:0]   ready_pad;

    // The ready vector is widened to every encodable select value so that
    // indexing it with out_sel is always in bounds; the padding is never
    // selected because only in-range beats are ever stored.
    always_comb begin
        ready_pad                 = '0;
        ready_pad[lpm_size-1:0]   = o_ready;
    end

    assign accept   = i_valid & i_ready;
    assign in_range = (32'(i_sel) < SIZE_U);
    assign load     = accept & in_range;
    assign out_fire = out_full & ready_pad[out_sel];
    assign out_free = ~out_full | out_fire;

    // Next occupancy of the skid stage; i_ready is registered from its
    // inverse so that the upstream sees backpressure from a flop.
    always_comb begin
        skid_full_next = skid_full;
        if (out_free && skid_full) begin
            skid_full_next = load;
        end else if (!out_free && load) begin
            skid_full_next = 1'b1;
        end
    end

    // Output/skid pipeline. The skid stage always holds the younger beat,
    // so draining it into the output stage before taking a new beat keeps
    // acceptance order. Dropped beats touch nothing but o_drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_full  <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            skid_full <= 1'b0;
            skid_data <= '0;
            skid_sel  <= '0;
            i_ready   <= 1'b0;
            o_drop    <= 1'b0;
        end else begin
            o_drop  <= accept & ~in_range;
            i_ready <= ~skid_full_next;
            if (out_free && skid_full) begin
                out_full <= 1'b1;
                out_data <= skid_data;
                out_sel  <= skid_sel;
                if (load) begin
                    skid_data <= i_data;
                    skid_sel  <= i_sel;
                end
                skid_full <= load;
            end else if (out_free) begin
                if (load) begin
                    out_full <= 1'b1;
                    out_data <= i_data;
                    out_sel  <= i_sel;
                end else if (out_fire) begin
                    out_full <= 1'b0;
                end
            end else if (load) begin
                skid_full <= 1'b1;
                skid_data <= i_data;
                skid_sel  <= i_sel;
            end
        end
    end

    // Decode the stored destination into the per-output valid vector.
    always_comb begin
        o_valid = '0;
        for (int k = 0; k < lpm_size; k++) begin
            o_valid[k] = out_full && (out_sel == lpm_widths'(k));
        end
    end

    assign o_data = out_data;

endmodule

// File: tb/tb_ct_demux.sv
// tb_ct_demux
//   Self-checking bench for ct_demux. A four-destination instance gets a
//   table of directed vectors, a mid-operation reset sequence and a long
//   randomized run predicted by a two-slot in-order queue model. A second,
//   three-destination instance covers the out-of-range drop path.
module tb_ct_demux;

    logic       clk;
    logic       reset;

    logic       i_valid;
    logic       i_ready;
    logic [7:0] i_data;
    logic [1:0] i_sel;
    logic [3:0] o_valid;
    logic [3:0] o_ready;
    logic [7:0] o_data;
    logic       o_drop;

    logic       i_valid3;
    logic       i_ready3;
    logic [7:0] i_data3;
    logic [1:0] i_sel3;
    logic [2:0] o_valid3;
    logic [2:0] o_ready3;
    logic [7:0] o_data3;
    logic       o_drop3;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       valid;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] rdy;
        logic [3:0] exp_valid;
        logic [7:0] exp_data;
        logic       exp_ready;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
    } beat_t;

    vec_t  vectors[$];
    beat_t model_q[$];

    ct_demux #(.lpm_width(8), .lpm_size(4), .lpm_widths(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .i_sel   (i_sel),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_drop  (o_drop)
    );

    ct_demux #(.lpm_width(8), .lpm_size(3), .lpm_widths(2)) dut3 (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid3),
        .i_ready (i_ready3),
        .i_data  (i_data3),
        .i_sel   (i_sel3),
        .o_valid (o_valid3),
        .o_ready (o_ready3),
        .o_data  (o_data3),
        .o_drop  (o_drop3)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a FAIL line on disagreement.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive the main instance for one clock edge, then settle 1 ns past it.
    task automatic applyStimulus(input logic v, input logic [1:0] s,
                                 input logic [7:0] d, input logic [3:0] r);
        i_valid = v;
        i_sel   = s;
        i_data  = d;
        o_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         accepted;
        int         cycles;
        logic       v;
        logic [1:0] s;
        logic [7:0] d;
        logic [3:0] r;
        logic       fire;
        logic       acc;
        logic [3:0] exp_v;

        reset    = 1'b1;
        i_valid  = 1'b0; i_sel  = '0; i_data  = '0; o_ready  = '0;
        i_valid3 = 1'b0; i_sel3 = '0; i_data3 = '0; o_ready3 = '0;

        // Directed table: each record is the input applied across one edge
        // and the outputs expected just after that edge.
        vectors.push_back('{1'b1, 2'd0, 8'h10, 4'b1111, 4'b0001, 8'h10, 1'b1});
        vectors.push_back('{1'b1, 2'd1, 8'h11, 4'b1111, 4'b0010, 8'h11, 1'b1});
        vectors.push_back('{1'b1, 2'd2, 8'h12, 4'b1111, 4'b0100, 8'h12, 1'b1});
        vectors.push_back('{1'b1, 2'd3, 8'h13, 4'b1111, 4'b1000, 8'h13, 1'b1});
        vectors.push_back('{1'b0, 2'd0, 8'h00, 4'b1111, 4'b0000, 8'h00, 1'b1});
        vectors.push_back('{1'b1, 2'd2, 8'hA0, 4'b1011, 4'b0100, 8'hA0, 1'b1});
        vectors.push_back('{1'b1, 2'd0, 8'hA1, 4'b1011, 4'b0100, 8'hA0, 1'b0});
        vectors.push_back('{1'b0, 2'd1, 8'hFF, 4'b1011, 4'b0100, 8'hA0, 1'b0});
        vectors.push_back('{1'b0, 2'd0, 8'h00, 4'b1111, 4'b0001, 8'hA1, 1'b1});
        vectors.push_back('{1'b0, 2'd0, 8'h00, 4'b1111, 4'b0000, 8'h00, 1'b1});
        vectors.push_back('{1'b1, 2'd3, 8'h77, 4'b0111, 4'b1000, 8'h77, 1'b1});
        vectors.push_back('{1'b0, 2'd0, 8'h00, 4'b0111, 4'b1000, 8'h77, 1'b1});
        vectors.push_back('{1'b0, 2'd0, 8'h00, 4'b1000, 4'b0000, 8'h00, 1'b1});

        // Reset state.
        @(posedge clk);
        #1;
        checkOutput("reset i_ready", 32'(i_ready), 0);
        checkOutput("reset o_valid", 32'(o_valid), 0);
        checkOutput("reset o_data",  32'(o_data), 0);
        checkOutput("reset o_drop",  32'(o_drop), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("release i_ready",  32'(i_ready), 1);
        checkOutput("release i_ready3", 32'(i_ready3), 1);

        // Directed vectors.
        for (int i = 0; i < vectors.size(); i++) begin
            applyStimulus(vectors[i].valid, vectors[i].sel, vectors[i].data, vectors[i].rdy);
            checkOutput($sformatf("vec%0d o_valid", i), 32'(o_valid), 32'(vectors[i].exp_valid));
            checkOutput($sformatf("vec%0d i_ready", i), 32'(i_ready), 32'(vectors[i].exp_ready));
            if (vectors[i].exp_valid != 4'b0000) begin
                checkOutput($sformatf("vec%0d o_data", i), 32'(o_data), 32'(vectors[i].exp_data));
            end
        end

        // Out-of-range select on the three-destination instance.
        i_valid3 = 1'b1; i_sel3 = 2'd3; i_data3 = 8'h55; o_ready3 = 3'b111;
        @(posedge clk);
        #1;
        checkOutput("drop pulse",   32'(o_drop3), 1);
        checkOutput("drop o_valid", 32'(o_valid3), 0);
        checkOutput("drop i_ready", 32'(i_ready3), 1);
        i_sel3 = 2'd2; i_data3 = 8'h66;
        @(posedge clk);
        #1;
        checkOutput("drop pulse end", 32'(o_drop3), 0);
        checkOutput("dut3 sel2 o_valid", 32'(o_valid3), 32'(3'b100));
        checkOutput("dut3 sel2 o_data",  32'(o_data3), 32'h66);
        i_valid3 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("dut3 idle o_valid", 32'(o_valid3), 0);

        // Fill both stages, then reset asynchronously between edges.
        applyStimulus(1'b1, 2'd1, 8'hB0, 4'b0000);
        applyStimulus(1'b1, 2'd2, 8'hB1, 4'b0000);
        checkOutput("full i_ready", 32'(i_ready), 0);
        checkOutput("full o_valid", 32'(o_valid), 32'(4'b0010));
        i_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async rst o_valid", 32'(o_valid), 0);
        checkOutput("async rst i_ready", 32'(i_ready), 0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        o_ready = 4'b1111;
        @(posedge clk);
        #1;
        checkOutput("post rst i_ready", 32'(i_ready), 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("post rst o_valid%0d", i), 32'(o_valid), 0);
            @(posedge clk);
            #1;
        end

        // Randomized run against the in-order two-slot queue model.
        accepted = 0;
        cycles   = 0;
        while (accepted < 10000 && cycles < 50000) begin
            exp_v = (model_q.size() > 0) ? 4'(1 << model_q[0].sel) : 4'b0000;
            checkOutput("rand o_valid", 32'(o_valid), 32'(exp_v));
            checkOutput("rand onehot",  32'($onehot0(o_valid)), 1);
            checkOutput("rand i_ready", 32'(i_ready), (model_q.size() < 2) ? 1 : 0);
            if (model_q.size() > 0) begin
                checkOutput("rand o_data", 32'(o_data), 32'(model_q[0].data));
            end
            v = ($urandom_range(0, 3) != 0);
            s = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 3) != 0);
            fire = (model_q.size() > 0) && r[model_q[0].sel];
            acc  = v && (model_q.size() < 2);
            applyStimulus(v, s, d, r);
            if (fire) void'(model_q.pop_front());
            if (acc) begin
                model_q.push_back('{s, d});
                accepted++;
            end
            cycles++;
        end
        if (accepted < 10000) begin
            checkOutput("rand beat budget", 32'(accepted), 10000);
        end

        // Drain whatever the model still holds.
        for (int i = 0; i < 4 && model_q.size() > 0; i++) begin
            checkOutput("drain o_valid", 32'(o_valid), 32'(4'(1 << model_q[0].sel)));
            checkOutput("drain o_data",  32'(o_data), 32'(model_q[0].data));
            applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);
            void'(model_q.pop_front());
        end
        checkOutput("drain empty o_valid", 32'(o_valid), 0);
        checkOutput("drain model empty", 32'(model_q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ct_demux.md
# ct_demux

Registered streaming demultiplexer: the inverse of `ct_mux`. It accepts one valid/ready stream carrying a select field and steers each beat to exactly one of `lpm_size` output streams. It sits on the split side of generated interconnect, where one source fans out to several sinks. A two-entry output/skid pipeline provides full throughput, a registered `i_ready`, and one cycle of latency.

## Interface
- `lpm_width`, 8: data width of each beat, in bits.
- `lpm_size`, 4: number of output streams; must be ≥ 2.
- `lpm_widths`, 2: width of `i_sel`; must satisfy 2^`lpm_widths` ≥ `lpm_size`.

Ports:
- `clk`  in  1  the single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  input beat valid.
- `i_ready`  out  1  input ready, driven directly from a flop.
- `i_data`  in  `lpm_width`  input payload.
- `i_sel`  in  `lpm_widths`  destination index for the beat.
- `o_valid`  out  `lpm_size`  per-output valid; at most one bit is set.
- `o_ready`  in  `lpm_size`  per-output ready.
- `o_data`  out  `lpm_width`  payload bus shared by all outputs.
- `o_drop`  out  1  one-cycle pulse: a beat with an out-of-range select was discarded.

## Operation
- Internal state:
  - Output stage: `out_full`, `out_data`, `out_sel`.
  - Skid stage: `skid_full`, `skid_data`, `skid_sel`.
- Definitions:
  - `accept` = `i_valid & i_ready`.
  - `in_range` = `i_sel` < `lpm_size`.
  - `out_fire` = `out_full & o_ready[out_sel]`.
  - `out_free` = `!out_full | out_fire`.
- Out-of-range beats: an accepted beat with `!in_range` is consumed and never stored. `o_drop` is 1 on the next cycle. No state changes.
- Per-edge update, first matching rule wins:
  - `out_free & skid_full`: output stage loads from the skid stage and `skid_full` goes to 0. If `accept & in_range` in the same cycle, the skid stage loads the new beat instead and stays full.
  - `out_free & !skid_full`: on `accept & in_range`, the output stage loads the beat. Otherwise `out_full` goes to 0 if `out_fire`.
  - `!out_free`: on `accept & in_range`, the skid stage loads the beat.
- `i_ready` next value = `!skid_full_next`.
- Outputs:
  - `o_valid[k]` = `out_full & (out_sel == k)`.
  - `o_data` = `out_data` for every output.
  - `o_ready` bits other than `o_ready[out_sel]` are ignored.
- Ordering: beats leave in acceptance order regardless of destination. A stalled destination blocks all destinations (head-of-line blocking, by design).
- Stability: while `o_valid[k]=1` and `o_ready[k]=0`, both `o_valid` and `o_data` hold stable.

## Timing
- Reset (async assert, all flops): `i_ready`=0, `o_valid`=0, `o_data`=0, `o_drop`=0, `out_full`=0, `skid_full`=0.
- Release: `i_ready` becomes 1 on the first rising edge after `reset` falls.
- Latency: a beat accepted at edge N is visible on `o_valid`/`o_data` after edge N (same cycle as `o_drop` for a dropped beat).
- Throughput: one beat per cycle sustained while the current destination is ready.
- Backpressure: `i_ready` falls one cycle after the output stage stalls with a beat arriving (the skid stage absorbs that beat). It rises the cycle after the skid stage drains.
- Mid-operation reset: both stored beats are discarded immediately, with no output pulse.
- Simultaneous `out_fire` and `accept` with the skid stage empty: the output stage reloads, with no bubble.

## Test plan
- Reset, then stream `i_sel`=0,1,2,3 with data 0x10–0x13, all `o_ready`=1 → `o_valid` = 0001, 0010, 0100, 1000 on consecutive cycles with matching data; `i_ready` stays 1.
- Hold `o_ready[2]`=0 while sending 0xA0 (sel 2) then 0xA1 (sel 0) → 0xA0 is held on `o_valid[2]`; 0xA1 goes into the skid stage; `i_ready`=0 on the next cycle; 0xA1 does not appear on `o_valid[0]`.
- Continue the previous case: release `o_ready[2]` → 0xA0 fires, then 0xA1 fires on `o_valid[0]` the next cycle; `i_ready` returns to 1 one cycle after the skid drains.
- `lpm_size`=3, `lpm_widths`=2, send `i_sel`=3 with data 0x55 → beat accepted, `o_drop` pulses for one cycle, no `o_valid` bit rises.
- Assert `reset` asynchronously while both stages are full → `o_valid`=0 and `i_ready`=0 immediately; after release, `i_ready`=1 after one edge and neither held beat ever appears.
- Random `i_valid`/`o_ready` over 10k beats, scoreboard per destination → order preserved, no loss or duplication, `o_valid` one-hot or zero every cycle.
